// File: rtl/line_window_stream.sv
//------------------------------------------------------------------------------
// line_window_stream
//
// Streaming row-window builder for the convolution datapath. Pixels arrive one
// per cycle in raster order over a valid/ready handshake and are written into
// a circular store of FILTER_SIZE rows. Once FILTER_SIZE rows are present the
// block presents the whole window (oldest row first) over a second valid/ready
// handshake, then advances by STRIDE rows for the next window. Rows left over
// after the last window of a frame are accepted and thrown away, and a single
// frame_done pulse closes the frame.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous reset, active low
//   i_in_valid     upstream pixel valid
//   i_in_pixel     upstream pixel data (PIXEL_W bits)
//   o_in_ready     block accepts a pixel this cycle (registered state decode)
//   o_out_valid    window valid
//   i_out_ready    consumer accepts the window
//   o_window_flat  row i (0 = oldest) at [(i*IMAGE_WIDTH+j)*PIXEL_W +: PIXEL_W]
//   o_out_row_idx  frame row index of window row 0
//   o_frame_done   one-cycle pulse once the frame is finished
//------------------------------------------------------------------------------
module line_window_stream #(
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 128,
   parameter int FILTER_SIZE  = 3,
   parameter int PIXEL_W      = 8,
   parameter int STRIDE       = 1
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst,
   input  logic                                       i_in_valid,
   input  logic [PIXEL_W-1:0]                         i_in_pixel,
   output logic                                       o_in_ready,
   output logic                                       o_out_valid,
   input  logic                                       i_out_ready,
   output logic [FILTER_SIZE*IMAGE_WIDTH*PIXEL_W-1:0] o_window_flat,
   output logic [$clog2(IMAGE_HEIGHT):0]              o_out_row_idx,
   output logic                                       o_frame_done
);

   localparam int NWIN   = (IMAGE_HEIGHT - FILTER_SIZE) / STRIDE + 1;
   localparam int COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int ROW_W  = $clog2(IMAGE_HEIGHT) + 1;
   localparam int HEAD_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
   localparam int WIN_W  = $clog2(NWIN + 1);
   localparam int ADV_W  = $clog2(STRIDE + 1);

   typedef enum logic [2:0] {
      FILL    = 3'd0,
      EMIT    = 3'd1,
      ADVANCE = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } StateType;

   StateType r_state;
   StateType w_nextState;

   logic [COL_W-1:0]   r_col;
   logic [ROW_W-1:0]   r_row;
   logic [HEAD_W-1:0]  r_head;
   logic [ADV_W-1:0]   r_adv;
   logic [WIN_W-1:0]   r_winCnt;
   logic [ROW_W-1:0]   r_outRowIdx;
   logic               r_inReady;
   logic               r_outValid;
   logic               r_frameDone;

   logic [PIXEL_W-1:0] r_store [FILTER_SIZE][IMAGE_WIDTH];

   logic               w_xfer;
   logic               w_lastCol;
   logic               w_rowDone;
   logic               w_accept;
   logic [HEAD_W-1:0]  w_headNext;

   // Physical store row that holds logical window row 'offset' when the
   // oldest row lives at 'head'. The store is a ring, so this is a modulo
   // add that never needs more than one subtraction.
   function automatic logic [HEAD_W-1:0] rotRow(input logic [HEAD_W-1:0] head,
                                               input int offset);
      int sum;
      sum = int'(head) + offset;
      if (sum >= FILTER_SIZE) begin
         sum = sum - FILTER_SIZE;
      end
      return HEAD_W'(sum);
   endfunction

   // Handshake qualifiers. A pixel moves only when the registered ready is
   // high, and a window is taken only while the block is actually presenting
   // one, so out_ready outside EMIT has no effect.
   assign w_xfer     = i_in_valid && r_inReady;
   assign w_lastCol  = (r_col == COL_W'(IMAGE_WIDTH - 1));
   assign w_rowDone  = w_xfer && w_lastCol;
   assign w_accept   = r_outValid && i_out_ready;
   assign w_headNext = (r_head == HEAD_W'(FILTER_SIZE - 1)) ? '0 : r_head + 1'b1;

   // State register. Reset always lands in FILL so the next frame starts
   // from pixel (0,0) no matter where the old frame was interrupted.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. FILL waits for the first FILTER_SIZE rows, EMIT holds
   // the window until it is taken, ADVANCE swallows STRIDE fresh rows, DRAIN
   // soaks up rows below the last window, and DONE is the one-cycle frame
   // boundary. The row counter counts completed rows, so after the last
   // window it tells directly whether any rows are still to come.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         FILL: begin
            if (w_rowDone && (r_row == ROW_W'(FILTER_SIZE - 1))) begin
               w_nextState = EMIT;
            end
         end
         EMIT: begin
            if (w_accept) begin
               if (r_winCnt != WIN_W'(NWIN - 1)) begin
                  w_nextState = ADVANCE;
               end else if (r_row < ROW_W'(IMAGE_HEIGHT)) begin
                  w_nextState = DRAIN;
               end else begin
                  w_nextState = DONE;
               end
            end
         end
         ADVANCE: begin
            if (w_rowDone && (r_adv == ADV_W'(STRIDE - 1))) begin
               w_nextState = EMIT;
            end
         end
         DRAIN: begin
            if (w_rowDone && (r_row == ROW_W'(IMAGE_HEIGHT - 1))) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = FILL;
         end
         default: begin
            w_nextState = FILL;
         end
      endcase
   end

   // Counters and registered handshake outputs. The outputs are decoded from
   // the next state so they line up with the state register on every cycle,
   // except straight after reset where in_ready is held low for one cycle.
   // in_ready therefore never depends on out_ready within a cycle. ADVANCE
   // moves the window origin by STRIDE only once all STRIDE rows are in.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_col       <= '0;
         r_row       <= '0;
         r_head      <= '0;
         r_adv       <= '0;
         r_winCnt    <= '0;
         r_outRowIdx <= '0;
         r_inReady   <= 1'b0;
         r_outValid  <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_inReady   <= (w_nextState == FILL) || (w_nextState == ADVANCE) ||
                        (w_nextState == DRAIN);
         r_outValid  <= (w_nextState == EMIT);
         r_frameDone <= (w_nextState == DONE);
         if (r_state == DONE) begin
            r_col       <= '0;
            r_row       <= '0;
            r_head      <= '0;
            r_adv       <= '0;
            r_winCnt    <= '0;
            r_outRowIdx <= '0;
         end else begin
            if (w_xfer) begin
               if (w_lastCol) begin
                  r_col  <= '0;
                  r_row  <= r_row + 1'b1;
                  r_head <= w_headNext;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            if (w_accept) begin
               r_winCnt <= r_winCnt + 1'b1;
               r_adv    <= '0;
            end
            if ((r_state == ADVANCE) && w_rowDone) begin
               if (r_adv == ADV_W'(STRIDE - 1)) begin
                  r_adv       <= '0;
                  r_outRowIdx <= r_outRowIdx + ROW_W'(STRIDE);
               end else begin
                  r_adv <= r_adv + 1'b1;
               end
            end
         end
      end
   end

   // Row store. Incoming pixels overwrite the ring slot at head, which in
   // ADVANCE is always the oldest row of the previous window. Rows taken in
   // DRAIN never reach a window, so they are not written at all.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int i = 0; i < FILTER_SIZE; i++) begin
            for (int j = 0; j < IMAGE_WIDTH; j++) begin
               r_store[i][j] <= '0;
            end
         end
      end else if (w_xfer && (r_state != DRAIN)) begin
         r_store[r_head][r_col] <= i_in_pixel;
      end
   end

   // Window presentation. In EMIT head points at the oldest row, so logical
   // row i comes from ring slot (head + i) mod FILTER_SIZE. This is a pure
   // mux over registers; no input reaches the window combinationally.
   always_comb begin
      o_window_flat = '0;
      for (int i = 0; i < FILTER_SIZE; i++) begin
         for (int j = 0; j < IMAGE_WIDTH; j++) begin
            o_window_flat[(i*IMAGE_WIDTH+j)*PIXEL_W +: PIXEL_W] = r_store[rotRow(r_head, i)][j];
         end
      end
   end

   assign o_in_ready    = r_inReady;
   assign o_out_valid   = r_outValid;
   assign o_out_row_idx = r_outRowIdx;
   assign o_frame_done  = r_frameDone;

endmodule
